alu_mul_seq: RTL and testbench

Multi-cycle 64x64 unsigned multiply sequencer that time-shares the 64-bit ripple ALU with the execute stage. It drives the ALU's operand and control inputs with a shift-add algorithm, one iteration per granted cycle, and produces the 128-bit product. It sits beside execute: the `alu_req`/`alu_gnt` pair lets the pipeline keep ALU priority, and the sequencer stalls without losing state whenever it is not granted.

---
 rtl/alu_pkg.sv | 24 ++
 rtl/alu_mul_seq.sv | 132 +++++++++++++
 tb/tb_alu_mul_seq.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the 64-bit ripple ALU and the units that time-share it.
//   - ALU control codes driven on alu_cntrl
//   - mul_state_t: control states of the multiply sequencer
// -----------------------------------------------------------------------------
package alu_pkg;

    localparam logic [2:0] ALU_PASS_B = 3'b000;
    localparam logic [2:0] ALU_ADD    = 3'b010;
    localparam logic [2:0] ALU_SUB    = 3'b011;
    localparam logic [2:0] ALU_AND    = 3'b100;
    localparam logic [2:0] ALU_OR     = 3'b101;
    localparam logic [2:0] ALU_XOR    = 3'b110;

    localparam int unsigned ALU_W = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mul_state_t;

endpackage

// File: rtl/alu_mul_seq.sv
// -----------------------------------------------------------------------------
// alu_mul_seq
// Multi-cycle 64x64 unsigned shift-add multiplier that borrows the shared
// 64-bit ALU for one add per granted cycle and yields a 128-bit product.
//
// Ports
//   clk          : clock, rising edge
//   reset        : asynchronous active-low reset
//   start_valid  : multiply request present          (in)
//   start_ready  : sequencer idle, accepts request   (out)
//   op_a, op_b   : multiplicand / multiplier, sampled on the start handshake
//   done_valid   : product available                 (out)
//   done_ready   : consumer takes the product        (in)
//   prod_hi/lo   : upper/lower product halves, zero outside DONE
//   alu_req      : sequencer wants the ALU this cycle
//   alu_gnt      : ALU is driven by the sequencer this cycle
//   alu_a/alu_b  : ALU operands, zero whenever alu_req is low
//   alu_cntrl    : ALU control code, zero whenever alu_req is low
//   alu_result   : combinational ALU result (same cycle)
//   alu_carry    : combinational ALU carry_out (same cycle)
// -----------------------------------------------------------------------------
module alu_mul_seq
    import alu_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start_valid,
    output logic        start_ready,
    input  logic [63:0] op_a,
    input  logic [63:0] op_b,
    output logic        done_valid,
    input  logic        done_ready,
    output logic [63:0] prod_hi,
    output logic [63:0] prod_lo,
    output logic        alu_req,
    input  logic        alu_gnt,
    output logic [63:0] alu_a,
    output logic [63:0] alu_b,
    output logic [2:0]  alu_cntrl,
    input  logic [63:0] alu_result,
    input  logic        alu_carry
);

    mul_state_t  state, state_nxt;
    logic [63:0] m;      // multiplicand
    logic [63:0] hi;     // running partial product, upper half
    logic [63:0] lo;     // multiplier bits not yet consumed / product low half
    logic [5:0]  cnt;    // iterations completed

    logic        load;   // start handshake this cycle
    logic        step;   // granted iteration this cycle

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Datapath registers. Each granted step computes {carry, hi + (lo[0] ? m : 0)}
    // on the ALU and shifts the 129-bit {carry, sum, lo} right by one; the bit
    // falling out of the sum becomes the new top bit of lo.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            m   <= '0;
            hi  <= '0;
            lo  <= '0;
            cnt <= '0;
        end else if (load) begin
            m   <= op_a;
            hi  <= '0;
            lo  <= op_b;
            cnt <= '0;
        end else if (step) begin
            hi  <= {alu_carry, alu_result[63:1]};
            lo  <= {alu_result[0], lo[63:1]};
            cnt <= cnt + 6'd1;   // wraps to 0 on the final step, harmless
        end
    end

    // Next state and outputs
    always_comb begin
        state_nxt   = state;
        load        = 1'b0;
        step        = 1'b0;
        start_ready = 1'b0;
        done_valid  = 1'b0;
        prod_hi     = '0;
        prod_lo     = '0;
        alu_req     = 1'b0;
        alu_a       = '0;
        alu_b       = '0;
        alu_cntrl   = '0;

        unique case (state)
            IDLE: begin
                start_ready = 1'b1;
                if (start_valid) begin
                    load      = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                alu_req   = 1'b1;
                alu_a     = hi;
                alu_b     = lo[0] ? m : '0;
                alu_cntrl = ALU_ADD;
                // Without a grant the ALU belongs to execute; hold everything.
                if (alu_gnt) begin
                    step = 1'b1;
                    if (cnt == 6'd63) begin
                        state_nxt = DONE;
                    end
                end
            end
            DONE: begin
                done_valid = 1'b1;
                prod_hi    = hi;
                prod_lo    = lo;
                if (done_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_alu_mul_seq.sv
// -----------------------------------------------------------------------------
// tb_alu_mul_seq
// Directed bench for alu_mul_seq with a behavioural stand-in for the shared
// ALU. Stimulus pushes the expected product into a queue on each request; a
// monitor pops and compares on every done handshake.
// -----------------------------------------------------------------------------
module tb_alu_mul_seq;

    logic        clk;
    logic        reset;
    logic        start_valid;
    logic        start_ready;
    logic [63:0] op_a;
    logic [63:0] op_b;
    logic        done_valid;
    logic        done_ready;
    logic [63:0] prod_hi;
    logic [63:0] prod_lo;
    logic        alu_req;
    logic        alu_gnt;
    logic [63:0] alu_a;
    logic [63:0] alu_b;
    logic [2:0]  alu_cntrl;
    logic [63:0] alu_result;
    logic        alu_carry;

    int total = 0;
    int bad   = 0;

    logic [127:0] exp_q[$];

    alu_mul_seq dut (
        .clk         (clk),
        .reset       (reset),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .op_a        (op_a),
        .op_b        (op_b),
        .done_valid  (done_valid),
        .done_ready  (done_ready),
        .prod_hi     (prod_hi),
        .prod_lo     (prod_lo),
        .alu_req     (alu_req),
        .alu_gnt     (alu_gnt),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_cntrl   (alu_cntrl),
        .alu_result  (alu_result),
        .alu_carry   (alu_carry)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Shared ALU stand-in: adds when granted with the ADD code; otherwise the
    // pipeline owns it, so present junk the sequencer must ignore.
    always_comb begin
        if (alu_gnt && alu_cntrl == 3'b010) begin
            {alu_carry, alu_result} = {1'b0, alu_a} + {1'b0, alu_b};
        end else begin
            alu_carry  = 1'b1;
            alu_result = 64'hA5A5_5A5A_0F0F_F0F0;
        end
    end

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Scoreboard monitor: compare on every done handshake.
    always @(negedge clk) begin
        if (reset && done_valid && done_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_product", {prod_hi, prod_lo}, 128'hX);
            end else begin
                chk("product", {prod_hi, prod_lo}, exp_q.pop_front());
            end
        end
    end

    function automatic bit is_hole(input int cyc);
        return cyc inside {3, 7, 8, 15, 22, 30, 31, 40, 51, 60};
    endfunction

    task automatic chk_idle(input string tag);
        chk({tag, "_ctl"}, {122'd0, start_ready, done_valid, alu_req, alu_cntrl}, 128'b100000);
        chk({tag, "_alu_ab"}, {alu_a, alu_b}, 128'd0);
        chk({tag, "_prod"}, {prod_hi, prod_lo}, 128'd0);
    endtask

    // Present a request and return #1 after the accepting edge.
    task automatic issue(input logic [63:0] a, input logic [63:0] b, input logic [127:0] expv);
        int n;
        exp_q.push_back(expv);
        op_a        = a;
        op_b        = b;
        start_valid = 1'b1;
        n = 0;
        while (!start_ready && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!start_ready) chk("start_ready_timeout", 128'd0, 128'd1);
        @(posedge clk);
        #1;
        start_valid = 1'b0;
    endtask

    // Count edges from the accept edge until done_valid shows. Cycle 1 starts
    // after the accept edge, so "done_valid at cycle 65" means 64 edges.
    task automatic wait_done(input bit holes, input int exp_edges, input bit chk_bz);
        int cyc;
        int edges;
        int bz_bad;
        cyc    = 1;
        edges  = 0;
        bz_bad = 0;
        alu_gnt = !(holes && is_hole(cyc));
        while (!done_valid && edges < 300) begin
            if (alu_req && alu_b != 64'd0) bz_bad++;
            @(posedge clk);
            #1;
            edges++;
            cyc++;
            alu_gnt = !(holes && is_hole(cyc));
        end
        alu_gnt = 1'b1;
        chk("latency", 128'(edges), 128'(exp_edges));
        if (chk_bz) chk("alu_b_zero", 128'(bz_bad), 128'd0);
    endtask

    task automatic release_done();
        done_ready = 1'b1;
        @(posedge clk);
        #1;
        done_ready = 1'b0;
    endtask

    initial begin
        int hb;
        reset       = 1'b0;
        start_valid = 1'b0;
        op_a        = '0;
        op_b        = '0;
        done_ready  = 1'b0;
        alu_gnt     = 1'b1;
        #12;
        chk_idle("reset");
        @(posedge clk);
        #1;
        reset = 1'b1;

        // 3 x 5
        issue(64'd3, 64'd5, 128'd15);
        wait_done(1'b0, 64, 1'b0);
        release_done();

        // all-ones squared exercises the carry path
        issue(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
              {64'hFFFF_FFFF_FFFF_FFFE, 64'h0000_0000_0000_0001});
        wait_done(1'b0, 64, 1'b0);
        release_done();

        // zero multiplicand: B operand never nonzero
        issue(64'd0, 64'h1234, 128'd0);
        wait_done(1'b0, 64, 1'b1);
        release_done();

        // 2^63 x 2 with ten ungranted RUN cycles
        issue(64'h8000_0000_0000_0000, 64'd2, {64'd1, 64'd0});
        wait_done(1'b1, 74, 1'b0);
        release_done();

        // DONE held 20 cycles while a new request waits
        issue(64'hDEAD_BEEF, 64'h1_0000_0000, {64'd0, 64'hDEAD_BEEF_0000_0000});
        wait_done(1'b0, 64, 1'b0);
        op_a        = 64'd6;
        op_b        = 64'd7;
        start_valid = 1'b1;
        hb = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (!done_valid || start_ready || alu_req || alu_a != 64'd0 ||
                {prod_hi, prod_lo} != {64'd0, 64'hDEAD_BEEF_0000_0000}) hb++;
        end
        chk("done_hold", 128'(hb), 128'd0);
        release_done();
        chk("idle_after_release", {126'd0, start_ready, done_valid}, 128'b10);
        exp_q.push_back(128'd42);
        @(posedge clk);
        #1;
        start_valid = 1'b0;
        chk("accept_after_release", 128'(alu_req), 128'd1);
        wait_done(1'b0, 64, 1'b0);
        release_done();

        // reset in RUN cycle 30 aborts; next multiply is clean
        issue(64'h55, 64'h33, 128'h10EF);
        for (int i = 0; i < 29; i++) begin
            @(posedge clk);
            #1;
        end
        #2;
        reset = 1'b0;
        #1;
        chk_idle("abort");
        exp_q.delete();
        @(posedge clk);
        #1;
        reset = 1'b1;
        issue(64'd7, 64'd9, 128'd63);
        wait_done(1'b0, 64, 1'b0);
        release_done();

        @(posedge clk);
        #1;
        chk("queue_drained", 128'(exp_q.size()), 128'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
